operation_selector_encoder: RTL

Front-end encoder that turns the board pushbuttons into the 3-bit ALU operation selector. KEY0/KEY1 are debounced and edge-detected to step the selected operation up or down; SW9 locks the current selection. The registered code drives the ALU selector and the 7-segment operation-symbol decoder, with op[2]=A, op[1]=B, op[0]=C.

---
 rtl/operation_selector_encoder.sv | 91 +++++++++
 1 files changed

// File: rtl/operation_selector_encoder.sv
// Pushbutton front end for the ALU operation selector: synchronizes and debounces
// KEY0/KEY1, steps a wrapping 3-bit op code on key presses, and honours the SW9 lock.
module operation_selector_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_OPS         = 8,
  parameter int unsigned RESET_OP        = 0
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       SW9,
  output logic [2:0] op,
  output logic       op_changed,
  output logic       locked
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    OP_MAX   = 3'(NUM_OPS - 1);
  localparam logic [2:0]    OP_RST   = 3'(RESET_OP);

  // Key vectors: bit 0 = KEY0 (step up), bit 1 = KEY1 (step down); all active-low.
  logic [1:0]         key_s1_q, key_s2_q;
  logic               sw_s1_q, sw_s2_q;
  logic [1:0]         deb_q, deb_d, deb_prev_q;
  logic [1:0]         press_q, press_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               chg_q, chg_d;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
      sw_s1_q  <= 1'b0;
      sw_s2_q  <= 1'b0;
    end else begin
      key_s1_q <= {KEY1, KEY0};
      key_s2_q <= key_s1_q;
      sw_s1_q  <= SW9;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // The counter never stores DEBOUNCE_CYCLES: the level flips on the cycle it would.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (key_s2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_LAST) deb_d[k] = key_s2_q[k];
        else                      cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
    press_d = deb_prev_q & ~deb_q;
  end

  always_comb begin
    op_d  = op_q;
    chg_d = 1'b0;
    if (!sw_s2_q && (press_q[0] ^ press_q[1])) begin
      chg_d = 1'b1;
      if (press_q[0]) op_d = (op_q == OP_MAX) ? '0 : op_q + 3'd1;
      else            op_d = (op_q == '0) ? OP_MAX : op_q - 3'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      deb_q      <= '1;
      deb_prev_q <= '1;
      cnt_q      <= '0;
      press_q    <= '0;
      op_q       <= OP_RST;
      chg_q      <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
      op_q       <= op_d;
      chg_q      <= chg_d;
    end
  end

  assign op         = op_q;
  assign op_changed = chg_q;
  assign locked     = sw_s2_q;

endmodule
